// File: rtl/serial2parallel.sv
// serial2parallel
// Collects an MSB-first serial stream into WIDTH-bit words. Each completed
// word is presented with a one-cycle valid strobe. An optional alignment
// input locks the word boundaries to the transmitter framing. A frame error
// pulse reports any partial word that realignment threw away.
//
// state | meaning
// ------+-----------------------------------------------------------
// HUNT  | waiting for the first align_sig; serial bits are discarded
// RUN   | word boundaries known; bits are shifted and counted
module serial2parallel #(
    parameter int WIDTH     = 2,
    parameter bit ALIGN_REQ = 1'b1
) (
    input  logic             clk_sig,
    input  logic             reset_sig,
    input  logic             serial_sig,
    input  logic             serial_en,
    input  logic             align_sig,
    output logic [WIDTH-1:0] parallel_sig,
    output logic             parallel_valid,
    output logic             frame_err,
    output logic             locked
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE_BIT  = CW'(1);

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam state_t RESET_STATE = ALIGN_REQ ? HUNT : RUN;

    // A one-bit word has no MSB/LSB split and no counter to speak of.
    if (WIDTH < 2) begin : g_width_check
        $error("serial2parallel: WIDTH must be at least 2");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [WIDTH-1:0] w_shift_in;
    logic [CW-1:0]    r_bit_cnt;
    logic [CW-1:0]    w_bit_cnt_nxt;
    logic [WIDTH-1:0] r_parallel;
    logic [WIDTH-1:0] w_parallel_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_frame_err;
    logic             w_frame_err_nxt;

    // The incoming bit always enters at the LSB, so the first bit of a word
    // has reached the MSB once WIDTH bits have been consumed.
    assign w_shift_in = {r_shift[WIDTH-2:0], serial_sig};

    // State, datapath and output registers; reset clears everything at once.
    always_ff @(posedge clk_sig or posedge reset_sig) begin
        if (reset_sig) begin
            r_state     <= RESET_STATE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_parallel  <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_parallel  <= w_parallel_nxt;
            r_valid     <= w_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    // Next-state and datapath decode. Everything holds when no bit is
    // consumed; the two strobes default low so they last a single cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_parallel_nxt  = r_parallel;
        w_valid_nxt     = 1'b0;
        w_frame_err_nxt = 1'b0;

        if (serial_en) begin
            case (r_state)
                HUNT: begin
                    if (align_sig) begin
                        w_shift_nxt   = w_shift_in;
                        w_bit_cnt_nxt = ONE_BIT;
                        w_state_nxt   = RUN;
                    end
                end
                RUN: begin
                    w_shift_nxt = w_shift_in;
                    if (align_sig) begin
                        // Align wins over completion: a word that would have
                        // finished on this bit is dropped as truncated.
                        w_bit_cnt_nxt   = ONE_BIT;
                        w_frame_err_nxt = (r_bit_cnt != '0);
                    end else if (r_bit_cnt == LAST_BIT) begin
                        w_parallel_nxt = w_shift_in;
                        w_valid_nxt    = 1'b1;
                        w_bit_cnt_nxt  = '0;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + ONE_BIT;
                    end
                end
                default: begin
                    w_state_nxt = RESET_STATE;
                end
            endcase
        end
    end

    assign parallel_sig   = r_parallel;
    assign parallel_valid = r_valid;
    assign frame_err      = r_frame_err;
    assign locked         = (r_state == RUN);

endmodule

// File: tb/tb_serial2parallel.sv
// Scoreboard bench for serial2parallel: a WIDTH=2 and a WIDTH=4 instance,
// both requiring alignment. Stimulus pushes hand-computed words together
// with the cycle they must appear on; monitors pop on every valid pulse.
module tb_serial2parallel;

    typedef struct packed {
        logic [3:0] w;
        int         c;
    } exp_t;

    logic       clk = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;

    logic       rst2, ser2, en2, al2;
    logic [1:0] p2;
    logic       v2, f2, lk2;

    logic       rst4, ser4, en4, al4;
    logic [3:0] p4;
    logic       v4, f4, lk4;

    exp_t       q2[$];
    exp_t       q4[$];
    int         obs_f2 = 0;
    int         obs_f4 = 0;

    serial2parallel #(.WIDTH(2), .ALIGN_REQ(1'b1)) u2 (
        .clk_sig(clk), .reset_sig(rst2), .serial_sig(ser2), .serial_en(en2),
        .align_sig(al2), .parallel_sig(p2), .parallel_valid(v2),
        .frame_err(f2), .locked(lk2)
    );

    serial2parallel #(.WIDTH(4), .ALIGN_REQ(1'b1)) u4 (
        .clk_sig(clk), .reset_sig(rst4), .serial_sig(ser4), .serial_en(en4),
        .align_sig(al4), .parallel_sig(p4), .parallel_valid(v4),
        .frame_err(f4), .locked(lk4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, req);
        end
    endtask

    // One clock of stimulus to the WIDTH=2 instance; push records the word
    // that must appear right after this edge.
    task automatic drv2(input logic b, input logic en, input logic al,
                        input bit push, input logic [1:0] w);
        exp_t e;
        ser2 = b; en2 = en; al2 = al;
        if (push) begin
            e.w = {2'b00, w};
            e.c = cyc + 1;
            q2.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drv4(input logic b, input logic en, input logic al,
                        input bit push, input logic [3:0] w);
        exp_t e;
        ser4 = b; en4 = en; al4 = al;
        if (push) begin
            e.w = w;
            e.c = cyc + 1;
            q4.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Sends a whole 4-bit word MSB first, optionally aligned on its first bit.
    task automatic word4(input logic [3:0] w, input logic align_first);
        for (int i = 3; i >= 0; i--)
            drv4(w[i], 1'b1, (i == 3) ? align_first : 1'b0, (i == 0), w);
    endtask

    // Monitors: every valid pulse must match the head of the queue, both in
    // value and in the cycle it shows up on.
    always @(negedge clk) begin
        exp_t e;
        if (v2 === 1'b1) begin
            checks++;
            if (q2.size() == 0) begin
                failures++;
                $display("FAIL u2_unexpected_valid got=%0h cyc=%0d", p2, cyc);
            end else begin
                e = q2.pop_front();
                if (p2 !== e.w[1:0] || cyc != e.c) begin
                    failures++;
                    $display("FAIL u2_word got=%0h@%0d expected=%0h@%0d", p2, cyc, e.w[1:0], e.c);
                end
            end
        end
        if (v4 === 1'b1) begin
            checks++;
            if (q4.size() == 0) begin
                failures++;
                $display("FAIL u4_unexpected_valid got=%0h cyc=%0d", p4, cyc);
            end else begin
                e = q4.pop_front();
                if (p4 !== e.w || cyc != e.c) begin
                    failures++;
                    $display("FAIL u4_word got=%0h@%0d expected=%0h@%0d", p4, cyc, e.w, e.c);
                end
            end
        end
        if (f2 === 1'b1) obs_f2++;
        if (f4 === 1'b1) obs_f4++;
    end

    initial begin
        logic [3:0] w;
        rst2 = 1'b1; ser2 = 1'b0; en2 = 1'b0; al2 = 1'b0;
        rst4 = 1'b1; ser4 = 1'b0; en4 = 1'b0; al4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_p2", {30'd0, p2}, 32'd0);
        chk("rst_v2", {31'd0, v2}, 32'd0);
        chk("rst_lk2", {31'd0, lk2}, 32'd0);
        chk("rst_p4", {28'd0, p4}, 32'd0);
        chk("rst_v4", {31'd0, v4}, 32'd0);
        chk("rst_f4", {31'd0, f4}, 32'd0);
        chk("rst_lk4", {31'd0, lk4}, 32'd0);
        rst2 = 1'b0;
        rst4 = 1'b0;
        drv4(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

        // Basic WIDTH=2: 1,0,1,1,0,1 -> 10, 11, 01
        drv2(1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
        chk("basic_lk2", {31'd0, lk2}, 32'd1);
        drv2(1'b0, 1'b1, 1'b0, 1'b1, 2'b10);
        drv2(1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
        drv2(1'b1, 1'b1, 1'b0, 1'b1, 2'b11);
        drv2(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        drv2(1'b1, 1'b1, 1'b0, 1'b1, 2'b01);
        drv2(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        drv2(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("basic_q2_empty", q2.size(), 32'd0);
        chk("basic_held_p2", {30'd0, p2}, 32'h1);
        chk("basic_f2", obs_f2, 32'd0);

        // Hunt: 10 unaligned bits are ignored
        for (int i = 0; i < 10; i++)
            drv4(logic'(i % 3 == 0), 1'b1, 1'b0, 1'b0, 4'h0);
        chk("hunt_locked_lo", {31'd0, lk4}, 32'd0);
        drv4(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        chk("hunt_locked_hi", {31'd0, lk4}, 32'd1);
        drv4(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        drv4(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        drv4(1'b0, 1'b1, 1'b0, 1'b1, 4'hC);

        // Gapped 4'hA; idle cycles carry junk data and a stray align
        drv4(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        drv4(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        drv4(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        drv4(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
        drv4(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        drv4(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
        drv4(1'b0, 1'b1, 1'b0, 1'b1, 4'hA);
        drv4(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        chk("gap_f4", obs_f4, 32'd0);

        // Realign on the 3rd bit: 1,0 dropped, then 0,1,1,0 -> 4'h6
        drv4(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        drv4(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        drv4(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
        chk("realign_ferr_pulse", {31'd0, f4}, 32'd1);
        drv4(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        drv4(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        drv4(1'b0, 1'b1, 1'b0, 1'b1, 4'h6);
        chk("realign_f4_count", obs_f4, 32'd1);

        // Redundant align and back-to-back words, one valid every 4 clocks
        word4(4'h9, 1'b1);
        word4(4'h3, 1'b0);
        word4(4'h5, 1'b0);
        word4(4'hF, 1'b0);
        drv4(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        chk("redundant_f4", obs_f4, 32'd1);

        // Reset after 2 of 4 bits clears outputs immediately
        drv4(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
        drv4(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        en4 = 1'b0;
        #2 rst4 = 1'b1;
        #1;
        chk("midrst_p4", {28'd0, p4}, 32'd0);
        chk("midrst_v4", {31'd0, v4}, 32'd0);
        chk("midrst_f4", {31'd0, f4}, 32'd0);
        chk("midrst_lk4", {31'd0, lk4}, 32'd0);
        @(posedge clk);
        #1 rst4 = 1'b0;
        word4(4'h5, 1'b1);
        drv4(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        chk("midrst_no_ferr", obs_f4, 32'd1);

        // Loopback from an MSB-first transmitter with random words
        for (int k = 0; k < 8; k++) begin
            w = 4'($urandom_range(0, 15));
            word4(w, 1'b1);
        end
        drv4(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        drv4(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        chk("loop_f4", obs_f4, 32'd1);
        chk("final_q4_empty", q4.size(), 32'd0);
        chk("final_q2_empty", q2.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
